// File: rtl/c1541_pkg.sv
// c1541_pkg: shared head-controller state type, default geometry and stepper phase decode
package c1541_pkg;
   typedef enum logic [1:0] {IDLE, SAVE, SETTLE} head_state_e;
   localparam int DEF_MAX_HT = 80;
   localparam int DEF_RESET_HT = 36;
   localparam logic [1:0] DIR_NONE = 2'd0;
   localparam logic [1:0] DIR_INC = 2'd1;
   localparam logic [1:0] DIR_DEC = 2'd2;
   // Forward phase order is 0,2,1,3: swapping the two bits yields the ordinal, so the
   // mod-4 ordinal difference is +1 for an inward step and -1 for an outward one.
   function automatic logic [1:0] step_dir(input logic [1:0] prev, input logic [1:0] cur);
      logic [1:0] d;
      d = {cur[0], cur[1]} - {prev[0], prev[1]};
      return d == 2'd1 ? DIR_INC : d == 2'd3 ? DIR_DEC : DIR_NONE;
   endfunction
endpackage

// File: rtl/c1541_step_decode.sv
// c1541_step_decode: stepper phase pair to saturated inc/dec pulses (bump pulse with C1541_HEAD_STATS_EN)
module c1541_step_decode
   import c1541_pkg::*;
#(
   parameter int HT_W = 7,
   parameter int MAX_HT = DEF_MAX_HT,
   parameter int MIN_HT = 1
) (
   input  logic            en,
   input  logic [1:0]      stp,
   input  logic [1:0]      stp_r,
   input  logic [HT_W-1:0] halftrack,
   output logic            inc,
`ifdef C1541_HEAD_STATS_EN
   output logic            bump,
`endif
   output logic            dec
);
   logic [1:0] dir;
   logic at_max, at_min;
   // A step against either end stop is swallowed; an outward one at MIN_HT is a head bump.
   always_comb begin
      dir = en ? step_dir(stp_r, stp) : DIR_NONE;
      at_max = halftrack >= HT_W'(MAX_HT);
      at_min = halftrack <= HT_W'(MIN_HT);
      inc = dir == DIR_INC && !at_max;
      dec = dir == DIR_DEC && !at_min;
`ifdef C1541_HEAD_STATS_EN
      bump = dir == DIR_DEC && at_min;
`endif
   end
endmodule

// File: rtl/c1541_head_ctrl.sv
// c1541_head_ctrl: head position, side, track-buffer save/settle arbitration and write-protect sense
// Optional C1541_HEAD_STATS_EN adds step_cnt/bump_cnt statistics outputs.
module c1541_head_ctrl
   import c1541_pkg::*;
#(
   parameter int MAX_HT = DEF_MAX_HT,
   parameter int MIN_HT = 1,
   parameter int RESET_HT = DEF_RESET_HT,
   parameter int NUM_SIDES = 1,
   parameter int SETTLE_TICKS = 16,
   parameter int CHG_TICKS = 30000000,
   parameter int HT_W = 7
) (
   input  logic            clk_c1541,
   input  logic            reset,
   input  logic            ce,
   input  logic            mtr,
   input  logic [1:0]      stp,
   input  logic            act,
   input  logic            side_sel,
   input  logic            buff_we,
   input  logic            disk_change,
   input  logic            disk_readonly,
   input  logic            save_ack,
   output logic [HT_W-1:0] halftrack,
   output logic [HT_W-2:0] track,
   output logic            side,
   output logic            track_valid,
   output logic            save_req,
   output logic [HT_W-2:0] save_track,
   output logic            save_side,
   output logic            wps_n,
`ifdef C1541_HEAD_STATS_EN
   output logic [15:0]     step_cnt,
   output logic [7:0]      bump_cnt,
`endif
   output logic            tr00_sense_n
);
   localparam int CW = $clog2(SETTLE_TICKS + 1);
   localparam int TW = $clog2(CHG_TICKS + 1);

   logic [HT_W-1:0] halftrack_q, halftrack_d;
   logic [1:0] stp_r_q, stp_r_d;
   logic act_r_q, act_r_d, dc_r_q, dc_r_d, side_r_q, side_r_d;
   logic dirty_q, dirty_d, ro_q, ro_d;
   logic [TW-1:0] chg_q, chg_d;
   logic inc, dec, side_chg, hc, act_fall, dc_rise, raise, new_side;
   head_state_e state_q;
   logic [CW-1:0] cnt_q;
   logic from_act_q, track_valid_q, save_req_q, save_side_q, side_q;
   logic [HT_W-2:0] track_q, save_track_q;
`ifdef C1541_HEAD_STATS_EN
   logic bump;
   logic [15:0] step_cnt_q, step_cnt_d;
   logic [7:0] bump_cnt_q, bump_cnt_d;
`endif

   c1541_step_decode #(.HT_W(HT_W), .MAX_HT(MAX_HT), .MIN_HT(MIN_HT)) u_dec (
      .en(ce && mtr),
      .stp(stp),
      .stp_r(stp_r_q),
      .halftrack(halftrack_q),
      .inc(inc),
`ifdef C1541_HEAD_STATS_EN
      .bump(bump),
`endif
      .dec(dec)
   );

   // Event detection and next-state of the head/dirty/disk-change datapath; history registers
   // follow their inputs during reset so no edge is reported across it.
   always_comb begin
      side_chg = NUM_SIDES == 2 && ce && side_sel != side_r_q;
      hc = inc || dec || side_chg;
      act_fall = ce && act_r_q && !act;
      dc_rise = ce && disk_change && !dc_r_q;
      raise = ce && state_q == IDLE && dirty_q && (hc || act_fall);
      new_side = NUM_SIDES == 2 ? side_sel : 1'b0;
      stp_r_d = (ce || reset) ? stp : stp_r_q;
      act_r_d = (ce || reset) ? act : act_r_q;
      dc_r_d = (ce || reset) ? disk_change : dc_r_q;
      side_r_d = (ce || reset) ? side_sel : side_r_q;
      halftrack_d = inc ? halftrack_q + HT_W'(1) : dec ? halftrack_q - HT_W'(1) : halftrack_q;
      dirty_d = !ce ? dirty_q : (disk_change || raise) ? 1'b0 : buff_we ? 1'b1 : dirty_q;
      ro_d = dc_rise ? disk_readonly : ro_q;
      chg_d = dc_rise ? TW'(CHG_TICKS) : (ce && chg_q != '0) ? chg_q - TW'(1) : chg_q;
`ifdef C1541_HEAD_STATS_EN
      step_cnt_d = (inc || dec) ? step_cnt_q + 16'd1 : step_cnt_q;
      bump_cnt_d = (bump && bump_cnt_q != 8'hFF) ? bump_cnt_q + 8'd1 : bump_cnt_q;
`endif
   end

   // Datapath registers.
   always_ff @(posedge clk_c1541) begin
      stp_r_q <= stp_r_d;
      act_r_q <= act_r_d;
      dc_r_q <= dc_r_d;
      side_r_q <= side_r_d;
      if (reset) begin
         halftrack_q <= HT_W'(RESET_HT);
         dirty_q <= 1'b0;
         ro_q <= 1'b0;
         chg_q <= '0;
`ifdef C1541_HEAD_STATS_EN
         step_cnt_q <= '0;
         bump_cnt_q <= '0;
`endif
      end else begin
         halftrack_q <= halftrack_d;
         dirty_q <= dirty_d;
         ro_q <= ro_d;
         chg_q <= chg_d;
`ifdef C1541_HEAD_STATS_EN
         step_cnt_q <= step_cnt_d;
         bump_cnt_q <= bump_cnt_d;
`endif
      end
   end

   // Save/settle arbiter: one write-back per departure, then a quiet period before the new track.
   always_ff @(posedge clk_c1541) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q <= '0;
         from_act_q <= 1'b0;
         track_q <= (HT_W-1)'(RESET_HT >> 1);
         side_q <= 1'b0;
         track_valid_q <= 1'b1;
         save_req_q <= 1'b0;
         save_track_q <= '0;
         save_side_q <= 1'b0;
      end else if (ce) begin
         case (state_q)
            IDLE:
               if (raise) begin
                  state_q <= SAVE;
                  save_req_q <= 1'b1;
                  save_track_q <= track_q;
                  save_side_q <= side_q;
                  from_act_q <= !hc;
                  track_valid_q <= 1'b0;
               end else if (hc) begin
                  state_q <= SETTLE;
                  cnt_q <= '0;
                  track_valid_q <= 1'b0;
               end
            SAVE: begin
               if (hc) from_act_q <= 1'b0;
               if (save_ack) begin
                  save_req_q <= 1'b0;
                  cnt_q <= '0;
                  if (from_act_q && !hc) begin
                     state_q <= IDLE;
                     track_valid_q <= 1'b1;
                  end else state_q <= SETTLE;
               end
            end
            SETTLE:
               if (hc) cnt_q <= '0;
               else if (cnt_q == CW'(SETTLE_TICKS - 1)) begin
                  state_q <= IDLE;
                  track_q <= halftrack_q[HT_W-1:1];
                  side_q <= new_side;
                  track_valid_q <= 1'b1;
               end else cnt_q <= cnt_q + CW'(1);
            default: state_q <= IDLE;
         endcase
      end
   end

   assign halftrack = halftrack_q;
   assign track = track_q;
   assign side = side_q;
   assign track_valid = track_valid_q;
   assign save_req = save_req_q;
   assign save_track = save_track_q;
   assign save_side = save_side_q;
   assign wps_n = !ro_q ^ (chg_q != '0);
   assign tr00_sense_n = !(halftrack_q <= HT_W'(MIN_HT + 1));
`ifdef C1541_HEAD_STATS_EN
   assign step_cnt = step_cnt_q;
   assign bump_cnt = bump_cnt_q;
`endif
endmodule

// File: tb/tb_c1541_head_ctrl.sv
// tb_c1541_head_ctrl: directed scenarios plus randomized traffic against a behavioural head model
module tb_c1541_head_ctrl;
   localparam int MAX_HT = 80, MIN_HT = 1, RESET_HT = 36, NUM_SIDES = 2;
   localparam int SETTLE = 16, CHG = 100, HT_W = 7;
   localparam int M_IDLE = 0, M_SAVE = 1, M_SETTLE = 2;

   logic clk_c1541 = 1'b0, reset = 1'b1, ce = 1'b1, mtr = 1'b0, act = 1'b0, side_sel = 1'b0;
   logic buff_we = 1'b0, disk_change = 1'b0, disk_readonly = 1'b0, save_ack = 1'b0;
   logic [1:0] stp = 2'd0;
   logic [HT_W-1:0] halftrack;
   logic [HT_W-2:0] track, save_track;
   logic side, track_valid, save_req, save_side, wps_n, tr00_sense_n;
`ifdef C1541_HEAD_STATS_EN
   logic [15:0] step_cnt;
   logic [7:0] bump_cnt;
`endif

   int n_chk = 0, n_fail = 0;
   int pos_of[4] = '{0, 2, 1, 3};
   int ph = 0;
   int m_ht, m_trk, m_side, m_valid, m_req, m_strk, m_sside, m_dirty, m_mode, m_left;
   int m_timer, m_ro, m_steps, m_bumps;
   bit m_back_idle;
   logic [1:0] p_stp;
   logic p_act, p_dc, p_side;

   c1541_head_ctrl #(
      .MAX_HT(MAX_HT), .MIN_HT(MIN_HT), .RESET_HT(RESET_HT), .NUM_SIDES(NUM_SIDES),
      .SETTLE_TICKS(SETTLE), .CHG_TICKS(CHG), .HT_W(HT_W)
   ) dut (
      .clk_c1541(clk_c1541), .reset(reset), .ce(ce), .mtr(mtr), .stp(stp), .act(act),
      .side_sel(side_sel), .buff_we(buff_we), .disk_change(disk_change),
      .disk_readonly(disk_readonly), .save_ack(save_ack), .halftrack(halftrack),
      .track(track), .side(side), .track_valid(track_valid), .save_req(save_req),
      .save_track(save_track), .save_side(save_side), .wps_n(wps_n),
`ifdef C1541_HEAD_STATS_EN
      .step_cnt(step_cnt), .bump_cnt(bump_cnt),
`endif
      .tr00_sense_n(tr00_sense_n)
   );

   always #5 clk_c1541 = ~clk_c1541;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference behaviour evaluated once per clock edge from the rules of the drive mechanics.
   task automatic model_step();
      int d;
      bit up, dn, bmp, hc, afall, rise, raise;
      if (reset) begin
         m_ht = RESET_HT; m_trk = RESET_HT / 2; m_side = 0; m_valid = 1; m_req = 0;
         m_strk = 0; m_sside = 0; m_dirty = 0; m_mode = M_IDLE; m_left = 0;
         m_timer = 0; m_ro = 0; m_steps = 0; m_bumps = 0; m_back_idle = 0;
         p_stp = stp; p_act = act; p_dc = disk_change; p_side = side_sel;
         return;
      end
      if (!ce) return;
      d = (pos_of[stp] - pos_of[p_stp] + 4) % 4;
      up = mtr && d == 1 && m_ht < MAX_HT;
      dn = mtr && d == 3 && m_ht > MIN_HT;
      bmp = mtr && d == 3 && m_ht <= MIN_HT;
      hc = up || dn || (side_sel != p_side);
      afall = p_act && !act;
      rise = disk_change && !p_dc;
      raise = m_mode == M_IDLE && m_dirty != 0 && (hc || afall);
      if (m_mode == M_IDLE) begin
         if (raise) begin
            m_mode = M_SAVE; m_req = 1; m_strk = m_trk; m_sside = m_side; m_valid = 0;
            m_back_idle = !hc;
         end else if (hc) begin
            m_mode = M_SETTLE; m_left = SETTLE; m_valid = 0;
         end
      end else if (m_mode == M_SAVE) begin
         if (hc) m_back_idle = 0;
         if (save_ack) begin
            m_req = 0;
            if (m_back_idle) begin m_mode = M_IDLE; m_valid = 1; end
            else begin m_mode = M_SETTLE; m_left = SETTLE; end
         end
      end else begin
         if (hc) m_left = SETTLE;
         else begin
            m_left--;
            if (m_left == 0) begin
               m_mode = M_IDLE; m_trk = m_ht / 2; m_side = side_sel; m_valid = 1;
            end
         end
      end
      m_ht = m_ht + int'(up) - int'(dn);
      if (disk_change || raise) m_dirty = 0; else if (buff_we) m_dirty = 1;
      if (rise) begin m_timer = CHG; m_ro = disk_readonly; end
      else if (m_timer > 0) m_timer--;
      if (up || dn) m_steps = (m_steps + 1) % 65536;
      if (bmp && m_bumps < 255) m_bumps++;
      p_stp = stp; p_act = act; p_dc = disk_change; p_side = side_sel;
   endtask

   task automatic tick();
      @(posedge clk_c1541);
      model_step();
      #1;
      chk("halftrack", halftrack, m_ht);
      chk("track", track, m_trk);
      chk("side", side, m_side);
      chk("track_valid", track_valid, m_valid);
      chk("save_req", save_req, m_req);
      chk("save_track", save_track, m_strk);
      chk("save_side", save_side, m_sside);
      chk("wps_n", wps_n, m_timer > 0 ? m_ro : 1 - m_ro);
      chk("tr00_sense_n", tr00_sense_n, m_ht <= MIN_HT + 1 ? 0 : 1);
`ifdef C1541_HEAD_STATS_EN
      chk("step_cnt", step_cnt, m_steps);
      chk("bump_cnt", bump_cnt, m_bumps);
`endif
   endtask

   task automatic move(input int dir);
      ph = (ph + dir + 4) % 4;
      stp = 2'(pos_of[ph]);
      tick();
   endtask

   task automatic do_reset();
      reset = 1; ce = 1; mtr = 1; ph = 0; stp = 2'd0; act = 0; side_sel = 0;
      buff_we = 0; disk_change = 0; disk_readonly = 0; save_ack = 0;
      tick();
      reset = 0;
   endtask

   initial begin
      int r, bias;
      do_reset();
      chk("rst_halftrack", halftrack, 36);
      chk("rst_track", track, 18);
      chk("rst_valid", track_valid, 1);
      chk("rst_save_req", save_req, 0);
      chk("rst_wps_n", wps_n, 1);
      chk("rst_tr00", tr00_sense_n, 1);
      // three inward steps then a quiet settle
      move(1); move(1); move(1);
      chk("seek_halftrack", halftrack, 39);
      chk("seek_invalid", track_valid, 0);
      repeat (SETTLE - 1) tick();
      chk("seek_still_settling", track_valid, 0);
      tick();
      chk("seek_valid", track_valid, 1);
      chk("seek_track", track, 19);
      // dirty buffer written back before leaving track 18
      do_reset();
      buff_we = 1; tick(); buff_we = 0;
      move(1);
      chk("save_req_up", save_req, 1);
      chk("save_track_18", save_track, 18);
      repeat (50) tick();
      chk("save_req_held", save_req, 1);
      save_ack = 1; tick(); save_ack = 0;
      chk("save_req_drop", save_req, 0);
      repeat (SETTLE - 1) tick();
      chk("save_settling", track_valid, 0);
      tick();
      chk("save_valid", track_valid, 1);
      chk("save_new_track", track, 18);
      chk("save_halftrack", halftrack, 37);
      // drive the head into the stop
      do_reset();
      repeat (40) move(-1);
      chk("bump_halftrack", halftrack, 1);
      chk("bump_tr00", tr00_sense_n, 0);
`ifdef C1541_HEAD_STATS_EN
      chk("bump_cnt_5", bump_cnt, 5);
      chk("step_cnt_35", step_cnt, 35);
`endif
      // motor off: phases ignored, no phantom step when it restarts
      do_reset();
      buff_we = 1; tick(); buff_we = 0;
      mtr = 0;
      repeat (6) move(1);
      chk("mtr_off_halftrack", halftrack, 36);
      chk("mtr_off_no_save", save_req, 0);
      mtr = 1; tick();
      chk("mtr_on_halftrack", halftrack, 36);
      chk("mtr_on_no_save", save_req, 0);
      // activity falling edge flushes a dirty buffer without a settle
      do_reset();
      act = 1; tick();
      buff_we = 1; tick(); buff_we = 0;
      act = 0; tick();
      chk("act_save_req", save_req, 1);
      chk("act_save_track", save_track, 18);
      chk("act_invalid", track_valid, 0);
      repeat (3) tick();
      save_ack = 1; tick(); save_ack = 0;
      chk("act_req_drop", save_req, 0);
      chk("act_valid_now", track_valid, 1);
      tick();
      chk("act_valid_stays", track_valid, 1);
      // read-only disk change: wps_n inverted for CHG ticks, dirty discarded
      do_reset();
      buff_we = 1; tick(); buff_we = 0;
      disk_readonly = 1; disk_change = 1; tick(); disk_change = 0;
      chk("chg_wps_start", wps_n, 1);
      repeat (CHG - 1) tick();
      chk("chg_wps_last", wps_n, 1);
      tick();
      chk("chg_wps_ro", wps_n, 0);
      move(1);
      chk("chg_no_save", save_req, 0);
      chk("chg_settling", track_valid, 0);
      // randomized traffic
      bias = 0;
      for (int i = 0; i < 4000; i++) begin
         if (i % 400 == 0) bias = $urandom_range(0, 2);
         reset = $urandom_range(0, 599) == 0;
         ce = $urandom_range(0, 3) != 0;
         mtr = $urandom_range(0, 15) != 0;
         r = $urandom_range(0, 99);
         if (bias == 0) ph = r < 40 ? (ph + 1) % 4 : r < 50 ? (ph + 3) % 4 : ph;
         else if (bias == 1) ph = r < 40 ? (ph + 3) % 4 : r < 50 ? (ph + 1) % 4 : ph;
         else ph = r < 3 ? (ph + 1) % 4 : r < 6 ? (ph + 3) % 4 : ph;
         if ($urandom_range(0, 49) == 0) ph = $urandom_range(0, 3);
         stp = 2'(pos_of[ph]);
         if ($urandom_range(0, 24) == 0) act = !act;
         buff_we = $urandom_range(0, 7) == 0;
         if ($urandom_range(0, 249) == 0) disk_change = !disk_change;
         disk_readonly = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 149) == 0) side_sel = !side_sel;
         save_ack = m_req != 0 && $urandom_range(0, 4) == 0;
         tick();
      end
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
